// File: rtl/mem_access_unit.sv
// Load/store sequencer between the datapath MAR/data registers and the byte-addressed RAM.
// Drives the MOV/MOC handshake, checks alignment, bounds the MOC wait and formats load data.
module mem_access_unit #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err_align,
  output logic              err_timeout,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_moc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign_ext;
  logic               r_err_align;
  logic               r_err_timeout;
  logic               w_accept;
  logic               w_misalign;
  logic               w_limit;

  function automatic logic [31:0] fmt_rdata(input logic [31:0] d, input logic [1:0] sz,
                                             input logic sx);
    case (sz)
      2'b00:   return {{24{sx & d[7]}}, d[7:0]};
      2'b01:   return {{16{sx & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] mask_wdata(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   return {24'b0, d[7:0]};
      2'b01:   return {16'b0, d[15:0]};
      2'b10:   return d;
      default: return 32'b0;
    endcase
  endfunction

  // A stale MOC from the previous access blocks acceptance until the RAM lets go of it.
  assign w_accept   = req && !mem_moc;
  assign w_misalign = (size == 2'b11) ||
                      (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);
  assign w_limit    = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = w_misalign ? S_DONE : S_REQ;
      S_REQ:     if (mem_moc || w_limit) w_next = S_RELEASE;
      S_RELEASE: if (!mem_moc) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_sign_ext    <= 1'b0;
      r_err_align   <= 1'b0;
      r_err_timeout <= 1'b0;
      rdata         <= 32'b0;
      mem_rw        <= 1'b0;
      mem_size      <= 2'b00;
      mem_addr      <= '0;
      mem_wdata     <= 32'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            mem_rw      <= rw;
            mem_size    <= size;
            mem_addr    <= addr;
            mem_wdata   <= mask_wdata(wdata, size);
            r_sign_ext  <= sign_ext;
            r_err_align <= w_misalign;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          // MOC on the limit cycle still counts as a successful access.
          if (mem_moc) begin
            if (mem_rw) rdata <= fmt_rdata(mem_rdata, mem_size, r_sign_ext);
          end else if (w_limit) begin
            r_err_timeout <= 1'b1;
          end
        end
        S_DONE: begin
          r_cnt         <= '0;
          r_err_align   <= 1'b0;
          r_err_timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_mov     = (r_state == S_REQ);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign err_align   = done & r_err_align;
  assign err_timeout = done & r_err_timeout;

endmodule
